// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning blocks.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REPEAT,
        RELEASE_WAIT
    } btn_state_t;

    // Converts a duration in microseconds into a count of clock periods (ns).
    function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned clk_per);
        longint unsigned ns;
        ns = 64'(us) * 64'd1000;
        return 32'(ns / 64'(clk_per));
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit or multi-bit level inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects one push-button; emits press, release
// and auto-repeat strobes plus the debounced level.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned CLK_PER     = 10,
    parameter int unsigned DEBOUNCE_US = 5000,
    parameter int unsigned HOLD_US     = 500000,
    parameter int unsigned REPEAT_US   = 100000,
    parameter bit          REPEAT_EN   = 1'b1
) (
    input  logic clk,
    input  logic CPU_RESET,
    input  logic button_in,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned DB_CYCLES   = us_to_cycles(DEBOUNCE_US, CLK_PER);
    localparam int unsigned HOLD_CYCLES = us_to_cycles(HOLD_US, CLK_PER);
    localparam int unsigned RPT_CYCLES  = us_to_cycles(REPEAT_US, CLK_PER);
    localparam int unsigned MAX_CYCLES  = max3(DB_CYCLES, HOLD_CYCLES, RPT_CYCLES);
    localparam int unsigned CNT_W       = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYCLES - 1);

    logic             btn_sync;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;

    sync_2ff #(
        .WIDTH(1)
    ) u_sync (
        .clk  (clk),
        .rst_i(CPU_RESET),
        .d_i  (button_in),
        .q_o  (btn_sync)
    );

    always_ff @(posedge clk) begin
        if (CPU_RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    // A change of the synchronised level always takes priority over a terminal count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_sync) begin
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_EN && (cnt_q == HOLD_LAST)) begin
                    state_d  = REPEAT;
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else if (!REPEAT_EN) begin
                    // No exit on hold time, so park the counter instead of letting it wrap.
                    cnt_d = cnt_q;
                end
            end
            REPEAT: begin
                if (!btn_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == RPT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == REPEAT) || (state_d == RELEASE_WAIT);
    end

    assign button_level  = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: one instance with auto-repeat, one without.
module tb_button_conditioner;

    localparam int unsigned DB   = 100;
    localparam int unsigned HOLD = 500;
    localparam int unsigned RPT  = 200;
    localparam int unsigned LAT  = DB + 2;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
    } ev_t;

    logic clk;
    logic cpu_reset;
    logic button_in;
    logic lvl1, prs1, rel1, rpt1;
    logic lvl2, prs2, rel2, rpt2;

    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned rpt2_seen = 0;
    ev_t q1[$];
    ev_t q2[$];

    button_conditioner #(
        .CLK_PER(10), .DEBOUNCE_US(1), .HOLD_US(5), .REPEAT_US(2), .REPEAT_EN(1'b1)
    ) u_dut (
        .clk(clk), .CPU_RESET(cpu_reset), .button_in(button_in),
        .button_level(lvl1), .press_pulse(prs1), .release_pulse(rel1), .repeat_pulse(rpt1)
    );

    button_conditioner #(
        .CLK_PER(10), .DEBOUNCE_US(1), .HOLD_US(5), .REPEAT_US(2), .REPEAT_EN(1'b0)
    ) u_dut_norpt (
        .clk(clk), .CPU_RESET(cpu_reset), .button_in(button_in),
        .button_level(lvl2), .press_pulse(prs2), .release_pulse(rel2), .repeat_pulse(rpt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int id, input int unsigned act,
                                input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s: got %0d, expected %0d (cycle %0d)", id, name, act, exp, cyc);
        end
    endfunction

    // Pops the next expected strobe whenever a DUT strobes and checks kind, time and level.
    function automatic void mon(input int id, input logic lvl, input logic p, input logic r,
                                input logic rp);
        ev_t         e;
        logic [1:0]  kind;
        int unsigned n;
        n = 32'(p) + 32'(r) + 32'(rp);
        if (n == 0) return;
        if (id == 2 && rp) rpt2_seen++;
        chk("strobe_onehot", id, n, 1);
        kind = p ? EV_PRESS : (r ? EV_RELEASE : EV_REPEAT);
        if (id == 1 && q1.size() != 0) e = q1.pop_front();
        else if (id == 2 && q2.size() != 0) e = q2.pop_front();
        else begin
            n_vec++;
            n_err++;
            $display("FAIL dut%0d unexpected_strobe: got kind %0d at cycle %0d, expected none",
                     id, kind, cyc);
            return;
        end
        chk("strobe_kind", id, 32'(kind), 32'(e.kind));
        n_vec++;
        if (cyc + 1 < e.cyc || cyc > e.cyc + 1) begin
            n_err++;
            $display("FAIL dut%0d strobe_cycle: got %0d, expected %0d +/-1 (kind %0d)",
                     id, cyc, e.cyc, e.kind);
        end
        if (p) chk("level_at_press", id, 32'(lvl), 1);
        if (r) chk("level_at_release", id, 32'(lvl), 0);
    endfunction

    always @(posedge clk) begin
        #1;
        mon(1, lvl1, prs1, rel1, rpt1);
        mon(2, lvl2, prs2, rel2, rpt2);
    end

    function automatic void expect_ev(input logic [1:0] kind, input int unsigned c, input bit both);
        q1.push_back('{kind: kind, cyc: c});
        if (both) q2.push_back('{kind: kind, cyc: c});
    endfunction

    // Drives the pin at the next falling edge; k is the rising edge that samples it.
    task automatic pin(input logic v, output int unsigned k);
        @(negedge clk);
        button_in = v;
        k = cyc + 1;
    endtask

    task automatic pin_at(input logic v, input int unsigned e);
        while (cyc + 1 < e) @(negedge clk);
        button_in = v;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_level"}, 1, 32'(lvl1), 0);
        chk({name, "_press"}, 1, 32'(prs1), 0);
        chk({name, "_release"}, 1, 32'(rel1), 0);
        chk({name, "_repeat"}, 1, 32'(rpt1), 0);
        chk({name, "_level"}, 2, 32'(lvl2), 0);
        chk({name, "_press"}, 2, 32'(prs2), 0);
        chk({name, "_release"}, 2, 32'(rel2), 0);
        chk({name, "_repeat"}, 2, 32'(rpt2), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned k, k2, p, g, r;
        button_in = 1'b0;
        cpu_reset = 1'b1;
        repeat (3) @(negedge clk);
        cpu_reset = 1'b0;
        check_outputs_zero("reset");

        // Clean press and release.
        pin(1'b1, k);
        expect_ev(EV_PRESS, k + LAT, 1'b1);
        idle(150);
        chk("clean_level_high", 1, 32'(lvl1), 1);
        chk("clean_level_high", 2, 32'(lvl2), 1);
        idle(148);
        pin(1'b0, k2);
        expect_ev(EV_RELEASE, k2 + LAT, 1'b1);
        idle(LAT + 50);
        chk("clean_level_low", 1, 32'(lvl1), 0);

        // Bounces shorter than the debounce time are rejected.
        repeat (5) begin
            pin(1'b1, k);
            idle(19);
            pin(1'b0, k);
            idle(19);
        end
        chk("bounce_level_low", 1, 32'(lvl1), 0);
        chk("bounce_level_low", 2, 32'(lvl2), 0);
        idle(150);
        repeat (5) begin
            pin(1'b1, k);
            idle(19);
            pin(1'b0, k);
            idle(19);
        end
        pin(1'b1, k);
        expect_ev(EV_PRESS, k + LAT, 1'b1);
        idle(300);
        pin(1'b0, k2);
        expect_ev(EV_RELEASE, k2 + LAT, 1'b1);
        idle(LAT + 50);

        // Auto-repeat: hold 1200 cycles past the press strobe.
        pin(1'b1, k);
        p = k + LAT;
        expect_ev(EV_PRESS, p, 1'b1);
        for (int i = 0; i < 4; i++) expect_ev(EV_REPEAT, p + HOLD + 32'(i) * RPT, 1'b0);
        pin_at(1'b0, p + 1200);
        chk("repeat_level_high", 1, 32'(lvl1), 1);
        expect_ev(EV_RELEASE, p + 1200 + LAT, 1'b1);
        idle(LAT + 50);

        // Release seen on the same cycle as a repeat terminal count: release wins.
        pin(1'b1, k);
        p = k + LAT;
        expect_ev(EV_PRESS, p, 1'b1);
        expect_ev(EV_REPEAT, p + HOLD, 1'b0);
        expect_ev(EV_REPEAT, p + HOLD + RPT, 1'b0);
        pin_at(1'b0, p + HOLD + 2 * RPT - 2);
        expect_ev(EV_RELEASE, p + HOLD + 2 * RPT - 2 + LAT, 1'b1);
        idle(LAT + 50);

        // Short release glitch while pressed restarts the hold time.
        pin(1'b1, k);
        p = k + LAT;
        expect_ev(EV_PRESS, p, 1'b1);
        g = p + 200;
        pin_at(1'b0, g);
        pin_at(1'b1, g + 15);
        button_in = 1'b0;
        chk("glitch_level_held", 1, 32'(lvl1), 1);
        chk("glitch_level_held", 2, 32'(lvl2), 1);
        pin_at(1'b1, g + 30);
        expect_ev(EV_REPEAT, g + 30 + 2 + HOLD, 1'b0);
        pin_at(1'b0, g + 30 + 2 + HOLD + 50);
        expect_ev(EV_RELEASE, g + 30 + 2 + HOLD + 50 + LAT, 1'b1);
        idle(LAT + 50);

        // Reset while repeating with the pin held forces a fresh press.
        pin(1'b1, k);
        p = k + LAT;
        expect_ev(EV_PRESS, p, 1'b1);
        expect_ev(EV_REPEAT, p + HOLD, 1'b0);
        while (cyc + 1 < p + HOLD + 50) @(negedge clk);
        cpu_reset = 1'b1;
        r = cyc + 1;
        @(negedge clk);
        cpu_reset = 1'b0;
        check_outputs_zero("midreset");
        expect_ev(EV_PRESS, r + 1 + LAT, 1'b1);
        pin_at(1'b0, r + 1 + LAT + 100);
        expect_ev(EV_RELEASE, r + 1 + LAT + 100 + LAT, 1'b1);
        idle(LAT + 100);

        chk("pending_events", 1, q1.size(), 0);
        chk("pending_events", 2, q2.size(), 0);
        chk("repeat_disabled_count", 2, rpt2_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
